// File: rtl/region_word_packer_if.sv
// Record-in / word-out link bundle for region_word_packer.
// Handshakes: a transfer happens on a rising clk edge where valid && ready; valid never waits on ready, and the sender holds payload stable while valid && !ready.
interface region_word_packer_if;
   logic        rec_valid;
   logic        rec_ready;
   logic [7:0]  rec_width;
   logic [7:0]  rec_height;
   logic [47:0] rec_counts;
   logic [31:0] data_out;
   logic        valid_out;
   logic        ready_in;

   modport master (
      output rec_valid, rec_width, rec_height, rec_counts, ready_in,
      input  rec_ready, data_out, valid_out
   );

   modport slave (
      input  rec_valid, rec_width, rec_height, rec_counts, ready_in,
      output rec_ready, data_out, valid_out
   );
endinterface

// File: rtl/region_word_packer.sv
// Buffers packed region records in a small FIFO and serializes each as two 32-bit words.
// Counts fully sent records and raises a sticky done after NUM_REGIONS of them.
module region_word_packer #(
   parameter logic [31:0] NUM_REGIONS = 32'd1000,
   parameter int          FIFO_DEPTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   region_word_packer_if.slave   bus,
   output logic [31:0]           sent_count,
   output logic                  done,
   output logic [1:0]            state_dbg
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOW  = 2'd1,
      S_HIGH = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [63:0] mem [FIFO_DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic        full;
   logic        empty;
   logic        push;
   logic        pop;
   logic [63:0] rec_word;
   logic [63:0] fifo_head;
   logic [63:0] hold;
   logic [31:0] data_d;
   logic        valid_d;
   logic        sent_inc;

   // Pointers carry one wrap bit so full and empty are distinguishable.
   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign fifo_head = mem[rd_ptr[AW-1:0]];

   assign bus.rec_ready = !full && !done && !rst;
   assign push          = bus.rec_valid && bus.rec_ready;
   assign rec_word      = {bus.rec_counts[47:16], bus.rec_height, bus.rec_width,
                           bus.rec_counts[15:0]};

   assign pop = !empty && ((state == S_IDLE) || ((state == S_HIGH) && bus.ready_in));

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= rec_word;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // State register, with the registered outputs and record bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         bus.valid_out <= 1'b0;
         bus.data_out  <= '0;
         hold          <= '0;
         sent_count    <= '0;
         done          <= 1'b0;
      end else begin
         state         <= state_nxt;
         bus.valid_out <= valid_d;
         bus.data_out  <= data_d;
         if (pop) hold <= fifo_head;
         if (sent_inc) begin
            sent_count <= sent_count + 32'd1;
            if (sent_count + 32'd1 == NUM_REGIONS) done <= 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (pop) state_nxt = S_LOW;
         S_LOW:  if (bus.ready_in) state_nxt = S_HIGH;
         S_HIGH: if (bus.ready_in) state_nxt = pop ? S_LOW : S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Next registered output word: a pop always presents word 0, a LOW handshake word 1.
   always_comb begin
      data_d   = bus.data_out;
      valid_d  = (state_nxt != S_IDLE);
      sent_inc = (state == S_HIGH) && bus.ready_in;
      if (pop) begin
         data_d = fifo_head[31:0];
      end else if ((state == S_LOW) && bus.ready_in) begin
         data_d = hold[63:32];
      end
   end

   assign state_dbg = state;

endmodule

// File: tb/tb_region_word_packer.sv
// Directed and randomized checks of region_word_packer against a record-level queue model.
module tb_region_word_packer;
   localparam int          DEPTH = 4;
   localparam logic [31:0] NUM   = 32'd3;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] sent_count;
   logic        done;
   logic [1:0]  state_dbg;

   always #5 clk = ~clk;

   region_word_packer_if bus ();

   region_word_packer #(.NUM_REGIONS(NUM), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .sent_count(sent_count), .done(done), .state_dbg(state_dbg)
   );

   int n_vec = 0;
   int n_err = 0;
   int hs_cnt = 0;
   int acc_cnt = 0;
   int cyc = 0;
   int first_hs = 0;
   int last_hs = 0;

   // Reference model: records waiting, plus the record in the output slot and words left to send.
   logic [63:0] fifo_q[$];
   logic [31:0] exp_q[$];
   logic [31:0] obs_q[$];
   logic [63:0] slot;
   int          slot_left;
   logic [31:0] m_sent;
   logic        m_done;

   function automatic logic [63:0] pack(input logic [7:0] w, input logic [7:0] h,
                                         input logic [47:0] c);
      return {c[47:16], h, w, c[15:0]};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      fifo_q.delete();
      slot      = '0;
      slot_left = 0;
      m_sent    = '0;
      m_done    = 1'b0;
   endtask

   task automatic model_check();
      chk("rec_ready", 64'(bus.rec_ready),
          64'(!rst && (fifo_q.size() < DEPTH) && !m_done));
      chk("valid_out", 64'(bus.valid_out), 64'(slot_left > 0));
      if (slot_left > 0)
         chk("data_out", 64'(bus.data_out), 64'((slot_left == 2) ? slot[31:0] : slot[63:32]));
      chk("sent_count", 64'(sent_count), 64'(m_sent));
      chk("done", 64'(done), 64'(m_done));
   endtask

   task automatic model_update();
      bit had;
      bit acc;
      if (rst) begin
         model_clear();
      end else begin
         had = fifo_q.size() > 0;
         acc = bus.rec_valid && (fifo_q.size() < DEPTH) && !m_done;
         if (slot_left > 0 && bus.ready_in) begin
            slot_left--;
            if (slot_left == 0) begin
               m_sent++;
               if (m_sent == NUM) m_done = 1'b1;
            end
         end
         if (slot_left == 0 && had) begin
            slot      = fifo_q.pop_front();
            slot_left = 2;
         end
         if (acc) fifo_q.push_back(pack(bus.rec_width, bus.rec_height, bus.rec_counts));
      end
   endtask

   task automatic step();
      #1;
      model_check();
      if (bus.valid_out && bus.ready_in) begin
         if (obs_q.size() == 0) first_hs = cyc;
         last_hs = cyc;
         obs_q.push_back(bus.data_out);
         hs_cnt++;
      end
      if (bus.rec_valid && bus.rec_ready) acc_cnt++;
      @(posedge clk);
      model_update();
      cyc++;
      #1;
   endtask

   task automatic set_rec(input logic [7:0] w, input logic [7:0] h, input logic [47:0] c);
      bus.rec_width  = w;
      bus.rec_height = h;
      bus.rec_counts = c;
   endtask

   task automatic set_rand_rec(output logic [63:0] p);
      logic [7:0]  w;
      logic [7:0]  h;
      logic [47:0] c;
      w = 8'($urandom());
      h = 8'($urandom());
      c = {16'($urandom()), $urandom()};
      set_rec(w, h, c);
      p = pack(w, h, c);
   endtask

   task automatic apply_reset(input int n);
      rst           = 1'b1;
      bus.rec_valid = 1'b0;
      bus.ready_in  = 1'b0;
      repeat (n) step();
      rst = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [63:0] p;
      logic [63:0] recs[$];

      rst            = 1'b1;
      bus.rec_valid  = 1'b0;
      bus.ready_in   = 1'b0;
      set_rec(8'd0, 8'd0, 48'd0);
      repeat (2) @(posedge clk);
      #1;
      model_clear();

      // Reset state
      chk("rst_valid_out", 64'(bus.valid_out), 64'd0);
      chk("rst_data_out", 64'(bus.data_out), 64'd0);
      chk("rst_sent", 64'(sent_count), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_rec_ready", 64'(bus.rec_ready), 64'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_rec_ready", 64'(bus.rec_ready), 64'd1);

      // Single record, ready held high
      set_rec(8'd40, 8'd50, 48'h060504030201);
      bus.rec_valid = 1'b1;
      bus.ready_in  = 1'b1;
      step();
      bus.rec_valid = 1'b0;
      chk("t1_idle_at_accept", 64'(bus.valid_out), 64'd0);
      step();
      chk("t1_w0_valid", 64'(bus.valid_out), 64'd1);
      chk("t1_w0", 64'(bus.data_out), 64'h32280201);
      step();
      chk("t1_w1_valid", 64'(bus.valid_out), 64'd1);
      chk("t1_w1", 64'(bus.data_out), 64'h06050403);
      step();
      chk("t1_drop", 64'(bus.valid_out), 64'd0);
      chk("t1_sent", 64'(sent_count), 64'd1);

      // Backpressure on word 0
      hs_cnt        = 0;
      bus.rec_valid = 1'b1;
      bus.ready_in  = 1'b0;
      step();
      bus.rec_valid = 1'b0;
      step();
      for (int i = 0; i < 3; i++) begin
         chk("t2_hold_w0", 64'(bus.data_out), 64'h32280201);
         chk("t2_hold_valid", 64'(bus.valid_out), 64'd1);
         step();
      end
      chk("t2_still_w0", 64'(bus.data_out), 64'h32280201);
      bus.ready_in = 1'b1;
      step();
      chk("t2_w1", 64'(bus.data_out), 64'h06050403);
      step();
      chk("t2_drop", 64'(bus.valid_out), 64'd0);
      chk("t2_hs", 64'(hs_cnt), 64'd2);
      chk("t2_sent", 64'(sent_count), 64'd2);

      // Fill with the output stalled
      apply_reset(2);
      acc_cnt = 0;
      recs.delete();
      bus.rec_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         set_rand_rec(p);
         recs.push_back(p);
         step();
      end
      chk("t3_accepted", 64'(acc_cnt), 64'(DEPTH + 1));
      #1;
      chk("t3_full_ready", 64'(bus.rec_ready), 64'd0);
      bus.rec_valid = 1'b0;
      bus.ready_in  = 1'b1;
      for (int i = 0; i < 2 * (DEPTH + 1); i++) begin
         p = recs[i / 2];
         chk("t3_drain_valid", 64'(bus.valid_out), 64'd1);
         chk("t3_drain_word", 64'(bus.data_out), 64'((i % 2 == 0) ? p[31:0] : p[63:32]));
         step();
      end
      chk("t3_drop", 64'(bus.valid_out), 64'd0);
      chk("t3_sent", 64'(sent_count), 64'(DEPTH + 1));
      chk("t3_done", 64'(done), 64'd1);

      // Streaming three records, reaching done
      apply_reset(2);
      hs_cnt = 0;
      obs_q.delete();
      exp_q.delete();
      bus.ready_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_rand_rec(p);
         exp_q.push_back(p[31:0]);
         exp_q.push_back(p[63:32]);
         bus.rec_valid = 1'b1;
         step();
      end
      bus.rec_valid = 1'b0;
      for (int k = 0; k < 20 && hs_cnt < 6; k++) step();
      chk("t4_hs_count", 64'(hs_cnt), 64'd6);
      chk("t4_done", 64'(done), 64'd1);
      chk("t4_sent", 64'(sent_count), 64'd3);
      chk("t4_no_bubble", 64'(last_hs - first_hs), 64'd5);
      for (int i = 0; i < 6; i++) begin
         if (i < obs_q.size()) chk("t4_word", 64'(obs_q[i]), 64'(exp_q[i]));
         else chk("t4_word_missing", 64'(i), 64'(obs_q.size()));
      end
      bus.rec_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         set_rand_rec(p);
         #1;
         chk("t4_ready_after_done", 64'(bus.rec_ready), 64'd0);
         step();
      end
      bus.rec_valid = 1'b0;

      // Reset in the middle of a record
      apply_reset(1);
      set_rand_rec(p);
      bus.rec_valid = 1'b1;
      bus.ready_in  = 1'b1;
      step();
      set_rand_rec(p);
      step();
      bus.rec_valid = 1'b0;
      step();
      rst = 1'b1;
      #1;
      chk("t5_ready_in_rst", 64'(bus.rec_ready), 64'd0);
      step();
      rst = 1'b0;
      chk("t5_valid_after_rst", 64'(bus.valid_out), 64'd0);
      chk("t5_sent_after_rst", 64'(sent_count), 64'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t5_flushed", 64'(bus.valid_out), 64'd0);
      end
      set_rand_rec(p);
      bus.rec_valid = 1'b1;
      step();
      bus.rec_valid = 1'b0;
      for (int k = 0; k < 10 && !bus.valid_out; k++) step();
      chk("t5_new_w0", 64'(bus.data_out), 64'(p[31:0]));
      step();
      chk("t5_new_w1", 64'(bus.data_out), 64'(p[63:32]));
      step();
      chk("t5_new_sent", 64'(sent_count), 64'd1);

      // Randomized traffic against the model
      for (int ep = 0; ep < 8; ep++) begin
         apply_reset(1);
         for (int c = 0; c < 60; c++) begin
            set_rand_rec(p);
            bus.rec_valid = 1'($urandom_range(0, 1));
            bus.ready_in  = ($urandom_range(0, 3) != 0);
            step();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
